pairing_io_ctrl: RTL
====================

Name: pairing_io_ctrl

Overview:
Host-side load/run/unload controller for the BN254 pairing core.
- Accepts one command per pairing job.
- Streams operand words into the core's operand RAM through the core's external write port (extin_en/addr/data).
- Pulses run with the selected function, then waits for endflag.
- Reads the result words back through the external read port and presents them on a back-pressured output stream with a credit-controlled skid FIFO.

Parameters:
DATA_W, 304, width of one redundant_poly_L3 RAM word
ADDR_W, 9, core RAM address width
RD_LAT, 3, cycles from core_extout_addr to valid core_extout_data
CNT_W, 24, run-cycle counter width
TIMEOUT_CYC, 2000000, watchdog limit in cycles (used only when the optional feature is enabled)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_func  in  4  n_func for core
cmd_load_base  in  ADDR_W  first write address
cmd_load_len  in  ADDR_W  number of operand words (0 = skip load)
cmd_res_base  in  ADDR_W  first result address
cmd_res_len  in  ADDR_W  number of result words (0 = skip unload)
s_valid/s_ready/s_data[DATA_W]/s_last  in/out/in/in  operand stream
m_valid/m_ready/m_data[DATA_W]/m_last  out/in/out/out  result stream
core_extin_en  out  1  write strobe
core_extin_addr  out  ADDR_W  write address
core_extin_data  out  DATA_W  write data
core_extout_addr  out  ADDR_W  read address
core_extout_data  in  DATA_W  read data
core_run  out  1  one-cycle start pulse
core_n_func  out  4  latched cmd_func
core_swrst  out  1  core abort
core_busy, core_endflag  in  1 each  core status
done  out  1  one-cycle job-complete pulse
err_len  out  1  sticky; s_last position mismatch
err_timeout  out  1  sticky; watchdog fired (0 when the feature is off)
run_cycles  out  CNT_W  cycles from core_run to core_endflag, saturating

Behaviour:
- Reset:
  - state=IDLE; FIFO empty.
  - All outputs 0, except cmd_ready=1 from the first cycle after rst deasserts.
  - core_swrst = rst (combinational), so a mid-job reset also aborts the core.
  - err flags are cleared by rst and by each accepted command.
- FSM: IDLE -> LOAD -> RUN -> WAIT -> UNLOAD -> DONE -> IDLE.
- IDLE:
  - On cmd_valid&cmd_ready, latch all cmd fields.
  - Next state is LOAD, or RUN if load_len==0.
- LOAD:
  - s_ready=1 while beats remaining > 0.
  - Each s handshake registers core_extin_en=1, addr=load_base+i (mod 2^ADDR_W wrap), data=s_data on the following cycle.
  - s_last is checked against beat index load_len-1. Any mismatch (early or missing) sets err_len; beat count alone terminates LOAD.
  - After the final handshake, go to RUN.
- RUN:
  - Entered the cycle after the final write strobe, so the last write is committed.
  - core_run=1 for exactly one cycle; core_n_func is held stable from command accept to DONE.
  - Clear run_cycles. Go to WAIT.
- WAIT:
  - run_cycles increments each cycle, saturating at all-ones.
  - On core_endflag, go to UNLOAD, or DONE if res_len==0.
  - core_extout_addr is not driven with reads while core_busy=1.
- UNLOAD:
  - FIFO depth = RD_LAT+2; credits = depth - occupancy - reads in flight.
  - Issue a read at res_base+j (wraps) each cycle while credits>0 and j<res_len.
  - A RD_LAT-deep valid shift register captures core_extout_data into the FIFO.
  - m_valid = FIFO non-empty; m_last asserts on word res_len-1.
  - m_data holds stable while m_valid&!m_ready.
  - Leave for DONE after the last word pops.
- DONE: done=1 for one cycle; return to IDLE (cmd_ready=1 next cycle).
- Boundary conditions:
  - core_endflag outside WAIT is ignored.
  - cmd_valid outside IDLE is ignored.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - m_ready held low: reads stop once credits reach 0, and no word is dropped.
  - load_len or res_len of 2^ADDR_W-1 wraps addresses correctly.

Optional Feature:
PAIRING_IO_TIMEOUT_EN
- Defined:
  - A watchdog counts cycles in WAIT.
  - On reaching TIMEOUT_CYC: core_swrst=1 for one cycle, err_timeout sets (sticky), the FSM goes to DONE, UNLOAD is skipped, and done pulses.
- Undefined: no watchdog logic; err_timeout is tied to 0 and WAIT waits indefinitely.

Test Plan:
- cmd(func=3, load_base=0x10, load_len=4, res_base=0x40, res_len=2), 4 beats with s_last on beat 4:
  - extin writes to 0x10..0x13, one cycle after each handshake.
  - core_run pulses once, the cycle after the 0x13 write.
  - After endflag: m stream delivers RAM[0x40], RAM[0x41], with m_last on the 2nd word.
  - done pulses once; err_len=0.
- load_len=3 with s_last on beat 2 -> 3 writes still occur; err_len=1 after beat 2; job completes normally.
- res_len=8, m_ready held low for 20 cycles:
  - Exactly RD_LAT+2=5 reads are issued, then reads stall.
  - After release, all 8 words arrive in address order; none is lost or duplicated.
- load_base=0x1FE, load_len=4 -> write addresses 0x1FE, 0x1FF, 0x000, 0x001.
- Model endflag arriving 1000 cycles after run -> run_cycles=1000. Assert rst mid-UNLOAD -> core_swrst high during rst; FIFO flushed; m_valid=0; cmd_ready=1 the cycle after rst drops.
- With PAIRING_IO_TIMEOUT_EN and TIMEOUT_CYC=50, endflag never sent:
  - 50 cycles into WAIT, core_swrst pulses and err_timeout=1.
  - done pulses; no m_valid.

Source files
------------

// File: rtl/pairing_io_ctrl.sv
// Host-side load/run/unload controller for the BN254 pairing core, with a credit-controlled result FIFO.
// Optional watchdog on the core run phase is enabled by defining PAIRING_IO_TIMEOUT_EN.
module pairing_io_ctrl #(
    parameter int DATA_W      = 304,
    parameter int ADDR_W      = 9,
    parameter int RD_LAT      = 3,
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_func,
    input  logic [ADDR_W-1:0] cmd_load_base,
    input  logic [ADDR_W-1:0] cmd_load_len,
    input  logic [ADDR_W-1:0] cmd_res_base,
    input  logic [ADDR_W-1:0] cmd_res_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              core_extin_en,
    output logic [ADDR_W-1:0] core_extin_addr,
    output logic [DATA_W-1:0] core_extin_data,
    output logic [ADDR_W-1:0] core_extout_addr,
    input  logic [DATA_W-1:0] core_extout_data,
    output logic              core_run,
    output logic [3:0]        core_n_func,
    output logic              core_swrst,
    input  logic              core_busy,
    input  logic              core_endflag,
    output logic              done,
    output logic              err_len,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  run_cycles
);

    // Streams transfer on a cycle where valid and ready are both high; ready never depends on valid.
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W:0] DEPTH_V = DEPTH[OCC_W:0];

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_UNLOAD, S_DONE
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] load_base_q, load_len_q, res_len_q;
    logic [ADDR_W-1:0] load_idx, rd_idx, out_idx;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [OCC_W-1:0]  fifo_count;
    logic [RD_LAT-1:0] rd_pipe;
    logic [OCC_W:0]    in_flight, used;
    logic              rd_issue, push, pop, load_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign s_ready   = (state == S_LOAD);
    assign m_valid   = (fifo_count != '0);
    assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last    = m_valid && (out_idx == res_len_q - 1'b1);
    assign push      = rd_pipe[RD_LAT-1];
    assign pop       = m_valid && m_ready;
    assign load_last = (load_idx == load_len_q - 1'b1);

    // Reads already in the latency pipe count against FIFO space so nothing can overflow.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + {{OCC_W{1'b0}}, rd_pipe[i]};
        end
        used     = {1'b0, fifo_count} + in_flight;
        rd_issue = (state == S_UNLOAD) && !core_busy && (used < DEPTH_V) && (rd_idx < res_len_q);
    end

`ifdef PAIRING_IO_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        swrst_q;
    assign core_swrst = rst | swrst_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign core_swrst     = rst;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            core_extin_en    <= 1'b0;
            core_extin_addr  <= '0;
            core_extin_data  <= '0;
            core_extout_addr <= '0;
            core_run         <= 1'b0;
            core_n_func      <= '0;
            done             <= 1'b0;
            err_len          <= 1'b0;
            run_cycles       <= '0;
            load_base_q      <= '0;
            load_len_q       <= '0;
            res_len_q        <= '0;
            load_idx         <= '0;
            rd_idx           <= '0;
            out_idx          <= '0;
`ifdef PAIRING_IO_TIMEOUT_EN
            wd_cnt           <= '0;
            swrst_q          <= 1'b0;
            err_timeout      <= 1'b0;
`endif
        end else begin
            core_extin_en <= 1'b0;
            core_run      <= 1'b0;
            done          <= 1'b0;
`ifdef PAIRING_IO_TIMEOUT_EN
            swrst_q       <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        core_n_func      <= cmd_func;
                        load_base_q      <= cmd_load_base;
                        load_len_q       <= cmd_load_len;
                        core_extout_addr <= cmd_res_base;
                        res_len_q        <= cmd_res_len;
                        load_idx         <= '0;
                        rd_idx           <= '0;
                        out_idx          <= '0;
                        err_len          <= 1'b0;
`ifdef PAIRING_IO_TIMEOUT_EN
                        err_timeout      <= 1'b0;
`endif
                        state <= (cmd_load_len == '0) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (s_valid) begin
                        core_extin_en   <= 1'b1;
                        core_extin_addr <= load_base_q + load_idx;
                        core_extin_data <= s_data;
                        load_idx        <= load_idx + 1'b1;
                        if (s_last != load_last) err_len <= 1'b1;
                        if (load_last) state <= S_RUN;
                    end
                end
                S_RUN: begin
                    core_run   <= 1'b1;
                    run_cycles <= '0;
`ifdef PAIRING_IO_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_endflag) begin
                        state <= (res_len_q == '0) ? S_DONE : S_UNLOAD;
                        done  <= (res_len_q == '0);
                    end else begin
                        if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
`ifdef PAIRING_IO_TIMEOUT_EN
                        if (wd_cnt == 32'(TIMEOUT_CYC - 1)) begin
                            swrst_q     <= 1'b1;
                            err_timeout <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
`endif
                    end
                end
                S_UNLOAD: begin
                    if (rd_issue) begin
                        core_extout_addr <= core_extout_addr + 1'b1;
                        rd_idx           <= rd_idx + 1'b1;
                    end
                    if (pop) begin
                        out_idx <= out_idx + 1'b1;
                        if (out_idx == res_len_q - 1'b1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_issue);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= core_extout_data;
    end

endmodule
